// File: rtl/seg7_msg_scroller_pkg.sv
// Shared types and constants for the 7-segment message scroller.
package seg7_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CLEAR = 2'd1,
        SEND  = 2'd2,
        HOLD  = 2'd3
    } seg7_state_e;

    localparam logic [7:0] SPACE_CHAR  = 8'h20;
    localparam int         FRAME_BEATS = 8;
    localparam int         SCROLL_GAP  = 3;

endpackage

// File: rtl/seg7_msg_scroller_if.sv
// Message-load and display-frame signals of the scroller.
interface seg7_msg_scroller_if #(
    parameter int LEN_W = 6
);
    logic             msg_clr;
    logic             msg_wr;
    logic [7:0]       msg_data;
    logic             run;
    logic [7:0]       char_out;
    logic             char_valid;
    logic             clear;
    logic             busy;
    logic [LEN_W-1:0] msg_len;

    modport master (
        output msg_clr, msg_wr, msg_data, run,
        input  char_out, char_valid, clear, busy, msg_len
    );

    modport slave (
        input  msg_clr, msg_wr, msg_data, run,
        output char_out, char_valid, clear, busy, msg_len
    );
endinterface

// File: rtl/seg7_msg_scroller_buf.sv
// Append-only message register file with length counter; writes when full are dropped.
module seg7_msg_buf #(
    parameter int MSG_DEPTH = 32,
    parameter int LEN_W     = $clog2(MSG_DEPTH) + 1,
    localparam int AW       = $clog2(MSG_DEPTH)
) (
    input  logic             clk_500hz,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             wr,
    input  logic [7:0]       wr_data,
    input  logic [AW-1:0]    rd_addr,
    output logic [7:0]       rd_data,
    output logic [LEN_W-1:0] len
);
    localparam logic [LEN_W-1:0] DEPTH_L = LEN_W'(MSG_DEPTH);

    logic [MSG_DEPTH-1:0][7:0] mem;
    logic                      full;

    assign full    = (len == DEPTH_L);
    assign rd_data = mem[rd_addr];

    // clear has priority over a same-cycle append
    always_ff @(posedge clk_500hz or negedge rst_n) begin
        if (!rst_n) begin
            len <= '0;
            mem <= '0;
        end else if (clr) begin
            len <= '0;
        end else if (wr && !full) begin
            mem[len[AW-1:0]] <= wr_data;
            len              <= len + 1'b1;
        end
    end
endmodule

// File: rtl/seg7_msg_scroller.sv
// Frame sequencer: clear pulse, 8 char beats, hold, scroll; feeds the 8-digit display.
// Define SEG7_SCROLL_GAP_EN to insert blank characters between scroll repetitions.
module seg7_msg_scroller
    import seg7_pkg::*;
#(
    parameter int MSG_DEPTH  = 32,
    parameter int HOLD_TICKS = 250,
    parameter int LEN_W      = $clog2(MSG_DEPTH) + 1
) (
    input  logic                 clk_500hz,
    input  logic                 rst_n,
    seg7_msg_scroller_if.slave   bus
);
    localparam int               AW        = $clog2(MSG_DEPTH);
    localparam int               HW        = $clog2(HOLD_TICKS + 1);
    localparam logic [HW-1:0]    HOLD_LAST = HW'(HOLD_TICKS - 1);
    localparam logic [LEN_W-1:0] BEATS_L   = LEN_W'(FRAME_BEATS);

    seg7_state_e      state, state_nxt;
    logic [LEN_W-1:0] offset, rd_idx, flen;
    logic [2:0]       k;
    logic [HW-1:0]    hcnt;
    logic             abort;
    logic [7:0]       char_out_q;
    logic             char_valid_q, clear_q;

    logic [LEN_W-1:0] src_idx, src_beat, src_len;
    logic             long_msg, in_range;
    logic [AW-1:0]    rd_addr;
    logic [7:0]       rd_data, src_char;

    seg7_msg_buf #(.MSG_DEPTH(MSG_DEPTH), .LEN_W(LEN_W)) u_buf (
        .clk_500hz (clk_500hz),
        .rst_n     (rst_n),
        .clr       (bus.msg_clr),
        .wr        (bus.msg_wr),
        .wr_data   (bus.msg_data),
        .rd_addr   (rd_addr),
        .rd_data   (rd_data),
        .len       (bus.msg_len)
    );

    // Length of the scroll cycle; the gap appends blanks only for scrolling messages.
    function automatic logic [LEN_W-1:0] eff_len(input logic [LEN_W-1:0] l);
`ifdef SEG7_SCROLL_GAP_EN
        return (l > BEATS_L) ? l + LEN_W'(SCROLL_GAP) : l;
`else
        return l;
`endif
    endfunction

    function automatic logic [LEN_W-1:0] wrap_inc(input logic [LEN_W-1:0] idx,
                                                  input logic [LEN_W-1:0] l);
        logic [LEN_W-1:0] nx;
        nx = idx + 1'b1;
        return (nx >= eff_len(l)) ? '0 : nx;
    endfunction

    // Character for the beat being loaded: beat 0 from CLEAR, beat k+1 from SEND.
    always_comb begin
        src_idx  = offset;
        src_beat = '0;
        src_len  = bus.msg_len;
        if (state == SEND) begin
            src_idx  = rd_idx;
            src_beat = LEN_W'(k) + 1'b1;
            src_len  = flen;
        end
        long_msg = (src_len >= BEATS_L);
        rd_addr  = long_msg ? src_idx[AW-1:0] : src_beat[AW-1:0];
        in_range = long_msg ? (src_idx < src_len) : (src_beat < src_len);
        src_char = in_range ? rd_data : SPACE_CHAR;
    end

    always_comb begin
        state_nxt = state;
        abort     = bus.msg_clr && (state != IDLE);
        case (state)
            IDLE:    if (bus.run && bus.msg_len != '0 && !bus.msg_clr) state_nxt = CLEAR;
            CLEAR:   state_nxt = SEND;
            SEND:    if (k == 3'd7) state_nxt = HOLD;
            HOLD: begin
                if (!bus.run)               state_nxt = IDLE;
                else if (hcnt == HOLD_LAST) state_nxt = CLEAR;
            end
            default: state_nxt = IDLE;
        endcase
        if (abort) state_nxt = IDLE;
    end

    always_ff @(posedge clk_500hz or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            offset       <= '0;
            rd_idx       <= '0;
            flen         <= '0;
            k            <= '0;
            hcnt         <= '0;
            char_out_q   <= '0;
            char_valid_q <= 1'b0;
            clear_q      <= 1'b0;
        end else begin
            state        <= state_nxt;
            clear_q      <= abort || (state_nxt == CLEAR);
            char_valid_q <= (state_nxt == SEND);
            char_out_q   <= (state_nxt == SEND) ? src_char : 8'h00;
            case (state)
                CLEAR: begin
                    flen   <= bus.msg_len;
                    rd_idx <= wrap_inc(offset, bus.msg_len);
                    k      <= '0;
                    hcnt   <= '0;
                end
                SEND: begin
                    rd_idx <= wrap_inc(rd_idx, flen);
                    k      <= k + 3'd1;
                end
                HOLD: begin
                    hcnt <= hcnt + 1'b1;
                    if (bus.run && hcnt == HOLD_LAST) begin
                        hcnt   <= '0;
                        offset <= (bus.msg_len > BEATS_L) ? wrap_inc(offset, bus.msg_len) : '0;
                    end
                end
                default: ;
            endcase
            if (bus.msg_clr) offset <= '0;
        end
    end

    assign bus.char_out   = char_out_q;
    assign bus.char_valid = char_valid_q;
    assign bus.clear      = clear_q;
    assign bus.busy       = (state != IDLE);
endmodule

// File: tb/tb_seg7_msg_scroller.sv
// Scroller bench: frame-phase reference model checked every cycle, directed scenarios, random traffic.
module tb_seg7_msg_scroller;
    localparam int DEPTH = 32;
    localparam int HOLD  = 250;
    localparam int LW    = 6;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    seg7_msg_scroller_if #(.LEN_W(LW)) bus ();

    seg7_msg_scroller #(.MSG_DEPTH(DEPTH), .HOLD_TICKS(HOLD), .LEN_W(LW)) dut (
        .clk_500hz (clk),
        .rst_n     (rst_n),
        .bus       (bus)
    );

    int n_chk = 0, n_fail = 0;

    // reference model: message array, scroll offset, and position within the frame
    logic [7:0] m_buf [DEPTH];
    int         m_len = 0, m_off = 0, m_flen = 0, m_phase = 0;
    bit         m_act = 0;
    bit         e_clr = 0, e_vld = 0;
    logic [7:0] e_chr = 8'h00;

    // frame capture from the DUT
    logic [63:0] frames_q[$];
    int          clr_cyc[$];
    logic [63:0] cur_frame = '0;
    int          cur_k = 0, cyc = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int eff(input int l);
`ifdef SEG7_SCROLL_GAP_EN
        return (l > 8) ? l + 3 : l;
`else
        return l;
`endif
    endfunction

    function automatic logic [7:0] beat_char(input int j);
        int idx;
        if (m_flen >= 8) begin
            idx = (m_off + j) % eff(m_flen);
            return (idx < m_flen) ? m_buf[idx] : 8'h20;
        end
        return (j < m_flen) ? m_buf[j] : 8'h20;
    endfunction

    // phase 0 = clear, 1..8 = beats, 9..8+HOLD = hold
    task automatic model_step();
        int l0;
        bit ab;
        if (!rst_n) begin
            m_len = 0; m_off = 0; m_act = 0; m_phase = 0;
            e_clr = 0; e_vld = 0; e_chr = 8'h00;
            return;
        end
        l0 = m_len;
        ab = bus.msg_clr && m_act;
        e_clr = 0; e_vld = 0; e_chr = 8'h00;
        if (ab) begin
            m_act = 0;
            e_clr = 1;
        end else if (!m_act) begin
            if (bus.run && l0 != 0 && !bus.msg_clr) begin
                m_act = 1; m_phase = 0; e_clr = 1;
            end
        end else begin
            if (m_phase == 0) begin
                m_flen = l0; m_phase = 1;
            end else if (m_phase <= 8) begin
                m_phase++;
            end else if (!bus.run) begin
                m_act = 0;
            end else if (m_phase == 8 + HOLD) begin
                m_off = (l0 > 8) ? (m_off + 1) % eff(l0) : 0;
                m_phase = 0;
            end else begin
                m_phase++;
            end
            if (m_act) begin
                if (m_phase == 0) e_clr = 1;
                else if (m_phase <= 8) begin
                    e_vld = 1;
                    e_chr = beat_char(m_phase - 1);
                end
            end
        end
        if (bus.msg_clr) begin
            m_len = 0; m_off = 0;
        end else if (bus.msg_wr && m_len < DEPTH) begin
            m_buf[m_len] = bus.msg_data;
            m_len++;
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        model_step();
        #1;
        chk("clear", bus.clear, e_clr);
        chk("char_valid", bus.char_valid, e_vld);
        chk("char_out", bus.char_out, e_chr);
        chk("busy", bus.busy, m_act);
        chk("msg_len", bus.msg_len, m_len);
        cyc++;
        if (bus.clear) begin
            clr_cyc.push_back(cyc);
            cur_k = 0;
            cur_frame = '0;
        end
        if (bus.char_valid) begin
            cur_frame = {cur_frame[55:0], bus.char_out};
            cur_k++;
            if (cur_k == 8) frames_q.push_back(cur_frame);
        end
    endtask

    task automatic wr_char(input logic [7:0] c);
        bus.msg_wr = 1'b1;
        bus.msg_data = c;
        cycle();
        bus.msg_wr = 1'b0;
    endtask

    task automatic write_str(input string s);
        for (int i = 0; i < s.len(); i++) wr_char(s[i]);
    endtask

    task automatic pulse_clr();
        bus.msg_clr = 1'b1;
        cycle();
        bus.msg_clr = 1'b0;
    endtask

    task automatic reset_capture();
        frames_q.delete();
        clr_cyc.delete();
        cur_k = 0;
        cur_frame = '0;
    endtask

    task automatic wait_frames(input int n, input int budget, input string name);
        int c = 0;
        while (frames_q.size() < n && c < budget) begin cycle(); c++; end
        chk(name, 64'(frames_q.size() >= n), 64'd1);
    endtask

    task automatic wait_beat(input int n, input int budget, input string name);
        int c = 0;
        while (cur_k != n && c < budget) begin cycle(); c++; end
        chk(name, 64'(cur_k), 64'(n));
    endtask

    task automatic wait_idle(input int budget, input string name);
        int c = 0;
        while (bus.busy && c < budget) begin cycle(); c++; end
        chk(name, 64'(bus.busy), 64'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [63:0] exp_f;
        int n;
        bus.msg_clr = 0; bus.msg_wr = 0; bus.msg_data = 8'h00; bus.run = 0;

        // reset state
        repeat (3) cycle();
        chk("rst_len", bus.msg_len, 0);
        chk("rst_busy", bus.busy, 0);
        rst_n = 1'b1;
        cycle();

        // short message: padded frames, no scroll, period 1+8+HOLD
        write_str("HI");
        reset_capture();
        bus.run = 1'b1;
        wait_frames(3, 1200, "hi_frames");
        exp_f = "HI      ";
        for (int i = 0; i < 3; i++) chk($sformatf("hi_frame%0d", i), frames_q[i], exp_f);
        chk("hi_period", 64'(clr_cyc[1] - clr_cyc[0]), 64'd259);
        bus.run = 1'b0;
        wait_idle(300, "hi_stop");

        // scrolling message
        pulse_clr();
        write_str("ABCDEFGHIJ");
        reset_capture();
        bus.run = 1'b1;
        wait_frames(4, 1300, "scroll_frames");
        exp_f = "ABCDEFGH"; chk("scroll_f0", frames_q[0], exp_f);
        exp_f = "BCDEFGHI"; chk("scroll_f1", frames_q[1], exp_f);
        exp_f = "CDEFGHIJ"; chk("scroll_f2", frames_q[2], exp_f);
`ifdef SEG7_SCROLL_GAP_EN
        exp_f = "DEFGHIJ ";
`else
        exp_f = "DEFGHIJA";
`endif
        chk("scroll_f3", frames_q[3], exp_f);
        bus.run = 1'b0;
        wait_idle(300, "scroll_stop");

        // overfill and clear/write collision
        pulse_clr();
        for (int i = 0; i < 33; i++) wr_char(8'h61 + 8'(i % 26));
        chk("full_len", bus.msg_len, 32);
        bus.msg_clr = 1'b1; bus.msg_wr = 1'b1; bus.msg_data = 8'h5a;
        cycle();
        bus.msg_clr = 1'b0; bus.msg_wr = 1'b0;
        chk("clr_wins_len", bus.msg_len, 0);

        // run low during HOLD
        write_str("HI");
        reset_capture();
        bus.run = 1'b1;
        wait_frames(1, 400, "hold_frame");
        cycle(); cycle();
        chk("hold_busy", bus.busy, 1);
        bus.run = 1'b0;
        cycle();
        chk("hold_stop_busy", bus.busy, 0);

        // run low during beat 3: frame still completes
        reset_capture();
        bus.run = 1'b1;
        wait_beat(4, 30, "beat3_reach");
        bus.run = 1'b0;
        n = 0;
        for (int c = 0; c < 20 && bus.busy; c++) begin
            cycle();
            if (bus.char_valid) n++;
        end
        chk("send_tail_beats", 64'(n), 64'd4);
        chk("send_tail_idle", bus.busy, 0);

        // msg_clr during beat 2
        reset_capture();
        bus.run = 1'b1;
        wait_beat(3, 30, "beat2_reach");
        bus.msg_clr = 1'b1;
        cycle();
        bus.msg_clr = 1'b0;
        chk("abort_valid", bus.char_valid, 0);
        chk("abort_clear", bus.clear, 1);
        chk("abort_busy", bus.busy, 0);
        chk("abort_len", bus.msg_len, 0);
        cycle();
        chk("abort_clear_done", bus.clear, 0);

        // asynchronous reset mid-SEND
        reset_capture();
        write_str("ABCDEFGHIJ");
        wait_beat(2, 300, "rst_beat_reach");
        #3;
        rst_n = 1'b0;
        #1;
        chk("arst_valid", bus.char_valid, 0);
        chk("arst_clear", bus.clear, 0);
        chk("arst_char", bus.char_out, 0);
        chk("arst_busy", bus.busy, 0);
        chk("arst_len", bus.msg_len, 0);
        cycle(); cycle();
        rst_n = 1'b1;
        n = 0;
        for (int c = 0; c < 20; c++) begin
            cycle();
            if (bus.clear) n++;
        end
        chk("empty_no_clear", 64'(n), 64'd0);
        chk("empty_idle", bus.busy, 0);

        // randomized traffic against the model
        for (int c = 0; c < 20000; c++) begin
            bus.msg_wr   = ($urandom_range(0, 29) == 0);
            bus.msg_data = 8'($urandom_range(32, 126));
            bus.msg_clr  = ($urandom_range(0, 1999) == 0);
            if ($urandom_range(0, 699) == 0) bus.run = ~bus.run;
            cycle();
        end
        bus.msg_wr = 0; bus.msg_clr = 0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/seg7_msg_scroller.md
Name: seg7_msg_scroller

Overview:
- Upstream feeder for the 8-digit 7-segment controller, clocked on the same 500 Hz scan clock.
- Holds an ASCII message of up to MSG_DEPTH characters, loaded by an append interface.
- Repeatedly emits display frames: one clear pulse, then 8 consecutive char/valid beats.
- Messages longer than 8 characters scroll left by one character every HOLD_TICKS clocks.

Parameters:
- MSG_DEPTH, 32: message buffer capacity in characters, power of two, at least 8.
- HOLD_TICKS, 250: clocks a frame is held before the next scroll step (0.5 s at 500 Hz), at least 1.
- LEN_W, $clog2(MSG_DEPTH)+1: width of the length and offset counters.

Ports:
- clk_500hz  in  1  display scan clock; the only clock.
- rst_n  in  1  asynchronous, active-low reset.
- msg_clr  in  1  one-cycle pulse: empty the message buffer.
- msg_wr  in  1  append msg_data to the buffer.
- msg_data  in  8  ASCII character to append.
- run  in  1  level: enable frame generation.
- char_out  out  8  ASCII character to the controller.
- char_valid  out  1  char_out is valid this cycle.
- clear  out  1  one-cycle clear of the controller buffer.
- busy  out  1  high when FSM is not IDLE.
- msg_len  out  LEN_W  current number of stored characters.

Behaviour:
- Reset: all outputs 0; msg_len=0; offset=0; hold counter=0; FSM=IDLE.
- Buffer:
  - msg_wr with msg_len<MSG_DEPTH writes buf[msg_len] and increments msg_len.
  - msg_wr when full is dropped silently.
  - msg_clr sets msg_len=0 and offset=0. If msg_clr and msg_wr occur in the same cycle, msg_clr wins and the write is dropped.
- FSM states: IDLE, CLEAR, SEND, HOLD.
- IDLE:
  - Moves to CLEAR when run=1 and msg_len!=0.
  - Outputs idle low.
- CLEAR:
  - clear=1 for exactly one cycle.
  - rd_idx loads offset, beat counter k=0.
  - Moves to SEND.
- SEND: 8 cycles, char_valid=1 every cycle.
  - Character source:
    - msg_len>=8: char_out=buf[rd_idx]; rd_idx increments and wraps to 0 when it reaches msg_len. No divider is used.
    - msg_len<8: beats k<msg_len output buf[k], remaining beats output 8'h20.
  - Moves to HOLD after k=7.
  - A frame, once started, always completes; run falling mid-SEND does not truncate it.
- HOLD:
  - Counts HOLD_TICKS cycles.
  - If run=0 in any HOLD cycle, go to IDLE immediately.
  - At expiry: if msg_len>8, offset advances (wraps to 0 at msg_len), otherwise offset stays 0; then go to CLEAR.
- msg_clr in any non-IDLE state: go to IDLE and pulse clear=1 in the following cycle so the display blanks. In-flight char_valid is suppressed from the msg_clr cycle onward.
- msg_wr while running: msg_len updates immediately. The new character becomes visible at the next frame. The current frame uses the msg_len sampled in CLEAR.
- Frame period: 1 + 8 + HOLD_TICKS clocks.
- Outputs are registered: char_out, char_valid and clear change only on the clock edge.
- Reset mid-frame: asynchronous return to the reset state; no further beats are issued.

Optional Feature:
- Macro: SEG7_SCROLL_GAP_EN.
- Defined:
  - When msg_len>8, the scroll sequence is the message followed by SCROLL_GAP (3) space characters, i.e. an effective length of msg_len+3.
  - rd_idx and offset wrap at msg_len+3; indices >= msg_len output 8'h20.
- Undefined: the message wraps directly end-to-start with no gap.

Decomposition:
- Package seg7_pkg:
  - FSM state enum.
  - SPACE_CHAR=8'h20.
  - FRAME_BEATS=8.
  - SCROLL_GAP=3.
- Sub-module seg7_msg_buf: MSG_DEPTH x 8 write-append/read-indexed register file with the msg_len counter and full flag. The FSM and the frame sequencer remain in the top module.

Test Plan:
- Reset, then write "HI" and set run=1 → one clear pulse, then beats 'H','I',' ',' ',' ',' ',' ',' '; offset stays 0 across 3 frames; frame period 259 clocks (HOLD_TICKS=250).
- Write "ABCDEFGHIJ" (10 chars), run=1 → frame0 "ABCDEFGH", frame1 "BCDEFGHI", frame2 "CDEFGHIJ", frame3 "DEFGHIJA". Repeat with SEG7_SCROLL_GAP_EN defined → frame3 "DEFGHIJ ".
- Write 33 chars with MSG_DEPTH=32 → msg_len=32, 33rd write dropped. msg_clr and msg_wr in the same cycle → msg_len=0.
- run low in HOLD → IDLE next cycle, busy=0. run low in SEND beat 3 → remaining beats 4-7 still issued, then IDLE.
- msg_clr during SEND beat 2 → char_valid=0 from that cycle, clear=1 one cycle later, FSM=IDLE, msg_len=0.
- rst_n low mid-SEND → all outputs 0 asynchronously. After release with run=1 and msg_len=0 → FSM stays IDLE with no clear pulse.
